tdc_capture: RTL and testbench

- Downstream consumer of the one-cycle `latch` pulse that the TDC control stage generates.
- On each `latch` it snapshots the delay-line thermometer code and a free-running coarse counter.
- It converts the thermometer code to a bubble-tolerant fine count and presents {coarse, fine} timestamps on a valid/ready output through a 2-entry buffer.
- Sits between the delay-line sampling registers/control stage and the readout logic.

---
 rtl/tdc_capture.sv | 134 +++++++++++++
 tb/tb_tdc_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_capture.sv
// tdc_capture: snapshots a delay-line thermometer code and a free-running
// coarse counter on each latch pulse. The code is turned into a
// bubble-tolerant popcount, and the {coarse, fine} timestamp is presented
// through a 2-entry first-word-fall-through buffer with a valid/ready output.
module tdc_capture #(
   parameter int TAP_NUM  = 64,
   parameter int COARSE_W = 16,
   parameter int FINE_W   = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                latch,
   input  logic [TAP_NUM-1:0]  therm,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic [FINE_W-1:0]   ts_fine,
   output logic                overflow
);

   typedef struct packed {
      logic [COARSE_W-1:0] coarse;
      logic [FINE_W-1:0]   fine;
   } ts_t;

   // Counting ones, not locating the leading one, keeps bubbles harmless.
   function automatic logic [FINE_W-1:0] popcount(input logic [TAP_NUM-1:0] v);
      logic [FINE_W-1:0] sum;
      sum = '0;
      for (int i = 0; i < TAP_NUM; i++) begin
         sum = sum + FINE_W'(v[i]);
      end
      return sum;
   endfunction

   logic [COARSE_W-1:0] cnt_q, cnt_d;
   logic                s0_valid_q, s0_valid_d;
   logic [TAP_NUM-1:0]  s0_therm_q, s0_therm_d;
   logic [COARSE_W-1:0] s0_coarse_q, s0_coarse_d;
   logic                s1_valid_q, s1_valid_d;
   ts_t                 s1_ts_q, s1_ts_d;
   ts_t                 mem_q [0:1];
   ts_t                 mem_d [0:1];
   logic                rd_ptr_q, rd_ptr_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic [1:0]          count_q, count_d;
   logic                overflow_q, overflow_d;

   logic pop, push, full, drop;
   ts_t  head;

   // Next-state logic for counter, capture/encode pipeline and buffer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      cnt_d       = cnt_q + COARSE_W'(1);

      s0_valid_d  = latch;
      s0_therm_d  = s0_therm_q;
      s0_coarse_d = s0_coarse_q;
      if (latch) begin
         s0_therm_d  = therm;
         s0_coarse_d = cnt_q;
      end

      s1_valid_d = s0_valid_q;
      s1_ts_d    = s1_ts_q;
      if (s0_valid_q) begin
         s1_ts_d.coarse = s0_coarse_q;
         s1_ts_d.fine   = popcount(s0_therm_q);
      end

      // Pop is evaluated first so a full buffer can take a push while draining.
      full = (count_q == 2'd2);
      pop  = (count_q != 2'd0) && ts_ready;
      push = s1_valid_q && (!full || pop);
      drop = s1_valid_q && full && !pop;

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
         mem_d[wr_ptr_q] = s1_ts_q;
         wr_ptr_d        = ~wr_ptr_q;
      end
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      overflow_d = overflow_q | drop;
   end

   // State registers; reset discards anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         s0_valid_q  <= 1'b0;
         s0_therm_q  <= '0;
         s0_coarse_q <= '0;
         s1_valid_q  <= 1'b0;
         s1_ts_q     <= '0;
         // NOTE: the buffer storage is reset because its head drives the outputs, which must read 0 after reset.
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         overflow_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         cnt_q       <= cnt_d;
         s0_valid_q  <= s0_valid_d;
         s0_therm_q  <= s0_therm_d;
         s0_coarse_q <= s0_coarse_d;
         s1_valid_q  <= s1_valid_d;
         s1_ts_q     <= s1_ts_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   // Head of the buffer falls through to the outputs.
   always_comb begin
      head      = mem_q[rd_ptr_q];
      ts_valid  = (count_q != 2'd0);
      ts_coarse = head.coarse;
      ts_fine   = head.fine;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_tdc_capture.sv
// Directed bench for tdc_capture: inputs are driven and outputs sampled on
// the falling edge, expected values are hand-computed per scenario.
module tb_tdc_capture;

   logic        clk;
   logic        rst;
   logic        latch;
   logic [63:0] therm;
   logic        ts_valid;
   logic        ts_ready;
   logic [15:0] ts_coarse;
   logic [6:0]  ts_fine;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Counter value the DUT should show in the current cycle.
   logic [15:0] exp_cnt;

   tdc_capture #(.TAP_NUM(64), .COARSE_W(16), .FINE_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .latch     (latch),
      .therm     (therm),
      .ts_valid  (ts_valid),
      .ts_ready  (ts_ready),
      .ts_coarse (ts_coarse),
      .ts_fine   (ts_fine),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference count of elapsed cycles since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) exp_cnt <= 16'd0;
      else     exp_cnt <= exp_cnt + 16'd1;
   end

   task automatic wait_cnt(input logic [15:0] v);
      int n;
      n = 0;
      while (exp_cnt !== v && n < 70000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_cnt !== v) begin
         n_fail++;
         $display("FAIL wait_cnt: got %0d expected %0d", exp_cnt, v);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (ts_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ts_valid); end
      n_checks++; if (ts_coarse !== 16'd0) begin n_fail++; $display("FAIL reset_coarse: got %0d expected 0", ts_coarse); end
      n_checks++; if (ts_fine !== 7'd0)    begin n_fail++; $display("FAIL reset_fine: got %0d expected 0", ts_fine); end
      n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      @(negedge clk);
      @(negedge clk);
      // Release reset and latch in the same cycle: counter must read 0.
      rst   = 1'b0;
      latch = 1'b1;
      therm = 64'h1;
      @(negedge clk);
      latch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1)   begin n_fail++; $display("FAIL first_valid: got %b expected 1", ts_valid); end
      n_checks++; if (ts_coarse !== 16'd0) begin n_fail++; $display("FAIL first_coarse: got %0d expected 0", ts_coarse); end
      n_checks++; if (ts_fine !== 7'd1)    begin n_fail++; $display("FAIL first_fine: got %0d expected 1", ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0)   begin n_fail++; $display("FAIL first_pop: got %b expected 0", ts_valid); end
   endtask

   task automatic test_basic();
      ts_ready = 1'b1;
      wait_cnt(16'd100);
      latch = 1'b1;
      therm = 64'h00000000000000FF;
      @(negedge clk);
      latch = 1'b0;
      therm = '1;
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0)     begin n_fail++; $display("FAIL basic_early: got %b expected 0", ts_valid); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1)     begin n_fail++; $display("FAIL basic_valid: got %b expected 1", ts_valid); end
      n_checks++; if (ts_coarse !== 16'd100) begin n_fail++; $display("FAIL basic_coarse: got %0d expected 100", ts_coarse); end
      n_checks++; if (ts_fine !== 7'd8)      begin n_fail++; $display("FAIL basic_fine: got %0d expected 8", ts_fine); end
      n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0)     begin n_fail++; $display("FAIL basic_once: got %b expected 0", ts_valid); end
   endtask

   task automatic test_bubble();
      latch = 1'b1;
      therm = 64'h00000000000002FD;
      @(negedge clk);
      therm = '1;
      @(negedge clk);
      therm = '0;
      @(negedge clk);
      latch = 1'b0;
      therm = 64'hFFFF;
      n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 7'd8)  begin n_fail++; $display("FAIL bubble_fine: got v=%b %0d expected v=1 8", ts_valid, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 7'd64) begin n_fail++; $display("FAIL ones_fine: got v=%b %0d expected v=1 64", ts_valid, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 7'd0)  begin n_fail++; $display("FAIL zeros_fine: got v=%b %0d expected v=1 0", ts_valid, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_drain: got %b expected 0", ts_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      ts_ready = 1'b0;
      wait_cnt(16'd10);
      latch = 1'b1;
      therm = 64'h1;
      @(negedge clk);
      therm = 64'h3;
      @(negedge clk);
      therm = 64'h7;
      @(negedge clk);
      latch = 1'b0;
      @(negedge clk);
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      @(negedge clk);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd10 || ts_fine !== 7'd1) begin n_fail++; $display("FAIL ovf_head: got v=%b %0d/%0d expected v=1 10/1", ts_valid, ts_coarse, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd10 || ts_fine !== 7'd1) begin n_fail++; $display("FAIL ovf_hold: got v=%b %0d/%0d expected v=1 10/1", ts_valid, ts_coarse, ts_fine); end
      ts_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd11 || ts_fine !== 7'd2) begin n_fail++; $display("FAIL ovf_second: got v=%b %0d/%0d expected v=1 11/2", ts_valid, ts_coarse, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got %b expected 0", ts_valid); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ts_ready = 1'b0;
      wait_cnt(16'd20);
      latch = 1'b1;
      therm = 64'hF;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      latch = 1'b0;
      @(negedge clk);
      // Buffer holds 20 and 21 now; 22 is pushed on the same edge as the pop.
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd20) begin n_fail++; $display("FAIL sim_first: got v=%b %0d expected v=1 20", ts_valid, ts_coarse); end
      ts_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd21) begin n_fail++; $display("FAIL sim_second: got v=%b %0d expected v=1 21", ts_valid, ts_coarse); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd22 || ts_fine !== 7'd4) begin n_fail++; $display("FAIL sim_third: got v=%b %0d/%0d expected v=1 22/4", ts_valid, ts_coarse, ts_fine); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty: got %b expected 0", ts_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_wrap();
      do_reset();
      ts_ready = 1'b1;
      wait_cnt(16'd65535);
      latch = 1'b1;
      therm = 64'h3;
      @(negedge clk);
      @(negedge clk);
      latch = 1'b0;
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd65535) begin n_fail++; $display("FAIL wrap_max: got v=%b %0d expected v=1 65535", ts_valid, ts_coarse); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: got v=%b %0d expected v=1 0", ts_valid, ts_coarse); end
      @(negedge clk);
      n_checks++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b expected 0", ts_valid); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      ts_ready = 1'b0;
      latch    = 1'b1;
      therm    = 64'h1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      latch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_ovf_pre: got %b expected 1", overflow); end
      latch = 1'b1;
      @(negedge clk);
      latch = 1'b0;
      rst   = 1'b1;
      #1;
      n_checks++; if (ts_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", ts_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      ts_ready = 1'b1;
      seen     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ts_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_ghost: got %b expected 0", seen); end
   endtask

   initial begin
      rst      = 1'b1;
      latch    = 1'b0;
      therm    = '0;
      ts_ready = 1'b1;
      test_reset();
      test_basic();
      test_bubble();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
